wb_lfsr_master: RTL

Wishbone master that sits directly upstream of the LFSR Wishbone slave and sequences its transactions. On a start pulse it optionally writes an 8-bit seed to slave address 0, then issues single-bit reads from address 1. It packs each group of 8 returned bits into a byte and hands the byte downstream on a valid/ready port. One transaction is outstanding at a time; stall and optional ack-timeout are handled.

---
 rtl/wb_lfsr_master.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_lfsr_master.sv
// Wishbone master that seeds the LFSR slave, reads bits one at a time and packs them into bytes.
// Optional ack timeout is compiled in with `define WB_LFSR_MASTER_TIMEOUT_EN.
module wb_lfsr_master #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_seed_wr,
  input  logic [7:0] i_seed,
  input  logic [3:0] i_nbytes,
  output logic       o_busy,
  output logic       o_wb_cyc,
  output logic       o_wb_stb,
  output logic       o_wb_we,
  output logic       o_wb_addr,
  output logic [7:0] o_wb_data,
  input  logic       i_wb_stall,
  input  logic       i_wb_data,
  input  logic       i_wb_ack,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_err
);

  typedef enum logic [2:0] {
    StIdle, StSeedReq, StSeedAck, StRdReq, StRdAck, StPush
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] seed_q, seed_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] nbytes_q, nbytes_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, addr_q, addr_d;
  logic       valid_q, valid_d, busy_q, busy_d;
  logic       timeout;
  logic       start_acc;

  assign start_acc = (state_q == StIdle) && i_start;

`ifdef WB_LFSR_MASTER_TIMEOUT_EN
  localparam logic [3:0] TmoLast = 4'(TIMEOUT_CYC - 1);

  logic [3:0] tmo_q, tmo_d;
  logic       err_q, err_d;

  // Counter is zero outside the ack states, so every entry into an ack state starts from zero.
  always_comb begin
    tmo_d   = '0;
    timeout = 1'b0;
    if (state_q == StSeedAck || state_q == StRdAck) begin
      tmo_d   = tmo_q + 4'd1;
      timeout = !i_wb_ack && (tmo_q == TmoLast);
    end
  end

  always_comb begin
    err_d = err_q;
    if (start_acc)    err_d = 1'b0;
    else if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign timeout        = 1'b0;
  assign o_err          = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    sr_d      = sr_q;
    byte_d    = byte_q;
    nbytes_d  = nbytes_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          seed_d    = i_seed;
          nbytes_d  = i_nbytes;
          bit_cnt_d = '0;
          sr_d      = '0;
          state_d   = i_seed_wr ? StSeedReq : StRdReq;
        end
      end
      StSeedReq: if (!i_wb_stall) state_d = StSeedAck;
      StSeedAck: begin
        if (i_wb_ack)     state_d = StRdReq;
        else if (timeout) state_d = StIdle;
      end
      StRdReq: if (!i_wb_stall) state_d = StRdAck;
      StRdAck: begin
        if (i_wb_ack) begin
          sr_d      = {sr_q[6:0], i_wb_data};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_d  = {sr_q[6:0], i_wb_data};
            state_d = StPush;
          end else begin
            state_d = StRdReq;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StPush: begin
        if (i_byte_ready) begin
          // A latched count of 0 wraps through 15..1, giving 16 bytes.
          nbytes_d  = nbytes_q - 4'd1;
          bit_cnt_d = '0;
          state_d   = (nbytes_q == 4'd1) ? StIdle : StRdReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    cyc_d   = (state_d == StSeedReq) || (state_d == StSeedAck) ||
              (state_d == StRdReq)   || (state_d == StRdAck);
    stb_d   = (state_d == StSeedReq) || (state_d == StRdReq);
    we_d    = (state_d == StSeedReq) || (state_d == StSeedAck);
    addr_d  = (state_d == StRdReq)   || (state_d == StRdAck);
    valid_d = (state_d == StPush);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      seed_q    <= '0;
      sr_q      <= '0;
      byte_q    <= '0;
      nbytes_q  <= '0;
      bit_cnt_q <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      sr_q      <= sr_d;
      byte_q    <= byte_d;
      nbytes_q  <= nbytes_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = we_q;
  assign o_wb_addr    = addr_q;
  assign o_wb_data    = seed_q;
  assign o_byte       = byte_q;
  assign o_byte_valid = valid_q;

endmodule
